// File: rtl/axi_lite_txn_limiter_pkg.sv
// axi_lite_txn_limiter_pkg: default AXI4-Lite channel/request/response types and counter sizing helper
// Callers may override the limiter's struct parameters with their own axi_pkg-derived types.
package axi_lite_txn_limiter_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned StrbWidth = DataWidth / 8;

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;

    typedef struct packed {
        addr_t      addr;
        logic [2:0] prot;
    } ax_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
    } w_chan_t;

    typedef struct packed {
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        data_t      data;
        logic [1:0] resp;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        logic    ar_ready;
        r_chan_t r;
        logic    r_valid;
    } rsp_t;

    function automatic int unsigned cnt_width(int unsigned max);
        return $clog2(max + 1);
    endfunction

endpackage

// File: rtl/axi_lite_txn_cnt.sv
// axi_lite_txn_cnt: saturating outstanding-transaction counter that opens a channel gate below Max
// The gate depends only on the registered count, so ready never reaches valid combinationally.
module axi_lite_txn_cnt
    import axi_lite_txn_limiter_pkg::*;
#(
    parameter int unsigned Max = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic open_o,
    output logic busy_o
);

    localparam int unsigned CntWidth = cnt_width(Max);
    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(Max);

    logic [CntWidth-1:0] cnt;
    logic                underflow;

    assign underflow = dec_i & (cnt == '0);
    assign open_o    = cnt < MaxCnt;
    assign busy_o    = |cnt;

    // A response with nothing outstanding is ignored so the count holds at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt <= '0;
        else if (inc_i & ~dec_i)
            cnt <= cnt + 1'b1;
        else if (dec_i & ~inc_i & ~underflow)
            cnt <= cnt - 1'b1;
    end

`ifndef SYNTHESIS
    a_underflow: assert property (@(posedge clk_i) disable iff (rst_i) !underflow)
        else $warning("axi_lite_txn_cnt: response handshake with no outstanding transaction");
    a_overflow: assert property (@(posedge clk_i) disable iff (rst_i) cnt <= MaxCnt)
        else $error("axi_lite_txn_cnt: count exceeds limit");
`endif

endmodule

// File: rtl/axi_lite_txn_limiter.sv
// axi_lite_txn_limiter: caps outstanding AXI4-Lite writes and reads ahead of the AXI4-Lite to AXI4 adapter
module axi_lite_txn_limiter
  import axi_lite_txn_limiter_pkg::*;
#(
  parameter int unsigned MaxWrTxns = 4,
  parameter int unsigned MaxRdTxns = 4,
  parameter type axi_lite_req_t = req_t,
  parameter type axi_lite_rsp_t = rsp_t
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  axi_lite_req_t slv_req_i,
  output axi_lite_rsp_t slv_resp_o,
  output axi_lite_req_t mst_req_o,
  input  axi_lite_rsp_t mst_resp_i,
  output logic          wr_busy_o,
  output logic          rd_busy_o
);
  if (MaxWrTxns < 1 || MaxRdTxns < 1) begin : g_param_check
    $fatal(1, "axi_lite_txn_limiter: MaxWrTxns and MaxRdTxns must be at least 1");
  end
  logic aw_open, w_open, ar_open;
  logic aw_busy, w_busy;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
  always_comb begin
    mst_req_o           = slv_req_i;
    mst_req_o.aw_valid  = slv_req_i.aw_valid & aw_open;
    mst_req_o.w_valid   = slv_req_i.w_valid & w_open;
    mst_req_o.ar_valid  = slv_req_i.ar_valid & ar_open;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_open;
    slv_resp_o.w_ready  = mst_resp_i.w_ready & w_open;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_open;
  end
  assign aw_hs = mst_req_o.aw_valid & mst_resp_i.aw_ready;
  assign w_hs  = mst_req_o.w_valid & mst_resp_i.w_ready;
  assign ar_hs = mst_req_o.ar_valid & mst_resp_i.ar_ready;
  assign b_hs  = mst_resp_i.b_valid & slv_req_i.b_ready;
  assign r_hs  = mst_resp_i.r_valid & slv_req_i.r_ready;
  axi_lite_txn_cnt #(.Max(MaxWrTxns)) u_aw (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (aw_hs),
    .dec_i  (b_hs),
    .open_o (aw_open),
    .busy_o (aw_busy)
  );
  axi_lite_txn_cnt #(.Max(MaxWrTxns)) u_w (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_hs),
    .dec_i  (b_hs),
    .open_o (w_open),
    .busy_o (w_busy)
  );
  axi_lite_txn_cnt #(.Max(MaxRdTxns)) u_ar (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (ar_hs),
    .dec_i  (r_hs),
    .open_o (ar_open),
    .busy_o (rd_busy_o)
  );
  assign wr_busy_o = aw_busy | w_busy;
endmodule

// File: tb/tb_axi_lite_txn_limiter.sv
// tb_axi_lite_txn_limiter: directed limit scenarios plus scoreboarded random traffic through a random-latency slave
module tb_axi_lite_txn_limiter;
    import axi_lite_txn_limiter_pkg::*;

    localparam int MaxWr = 2;
    localparam int MaxRd = 2;
    localparam int NumWr = 5000;
    localparam int NumRd = 5000;

    logic clk = 1'b0;
    logic rst;
    req_t slv_req, mst_req;
    rsp_t slv_resp, mst_resp;
    logic wr_busy, rd_busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_lite_txn_limiter #(
        .MaxWrTxns (MaxWrTxns_p()),
        .MaxRdTxns (MaxRdTxns_p())
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .wr_busy_o  (wr_busy),
        .rd_busy_o  (rd_busy)
    );

    function automatic int unsigned MaxWrTxns_p();
        return MaxWr;
    endfunction

    function automatic int unsigned MaxRdTxns_p();
        return MaxRd;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    addr_t      aw_q[$], ar_q[$], s_aw[$], s_ar[$];
    data_t      w_q[$], s_w[$], exp_r[$];
    logic [1:0] exp_b[$];
    int         m_aw, m_w, m_ar, wr_gen, rd_gen, b_dly, r_dly, cyc;
    logic       aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_pend, w_pend, ar_pend, done;
    addr_t      a;
    data_t      d;

    initial begin
        // reset with a request and downstream ready held
        slv_req = '0;
        mst_resp = '0;
        rst = 1'b1;
        slv_req.aw_valid = 1'b1;
        mst_resp.aw_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_aw_cnt", 32'(dut.u_aw.cnt), 0);
        check("rst_w_cnt", 32'(dut.u_w.cnt), 0);
        check("rst_ar_cnt", 32'(dut.u_ar.cnt), 0);
        check("rst_wr_busy", wr_busy, 0);
        check("rst_rd_busy", rd_busy, 0);
        check("rst_mst_aw_valid", mst_req.aw_valid, 1);
        slv_req.aw_valid = 1'b0;
        step();

        // write fill: two writes pass, third blocked until a B returns
        mst_resp.w_ready = 1'b1;
        slv_req.aw_valid = 1'b1;
        slv_req.w_valid = 1'b1;
        slv_req.b_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fill_aw_ready", slv_resp.aw_ready, 1);
            check("fill_w_ready", slv_resp.w_ready, 1);
            step();
        end
        @(negedge clk);
        check("full_aw_ready", slv_resp.aw_ready, 0);
        check("full_w_ready", slv_resp.w_ready, 0);
        check("full_mst_aw_valid", mst_req.aw_valid, 0);
        check("full_mst_w_valid", mst_req.w_valid, 0);
        check("full_wr_busy", wr_busy, 1);
        check("full_aw_cnt", 32'(dut.u_aw.cnt), 2);
        mst_resp.b_valid = 1'b1;
        step();
        mst_resp.b_valid = 1'b0;
        @(negedge clk);
        check("reopen_aw_ready", slv_resp.aw_ready, 1);
        check("reopen_w_ready", slv_resp.w_ready, 1);
        check("reopen_mst_aw_valid", mst_req.aw_valid, 1);
        step();
        slv_req.aw_valid = 1'b0;
        slv_req.w_valid = 1'b0;
        check("third_aw_cnt", 32'(dut.u_aw.cnt), 2);
        check("third_w_cnt", 32'(dut.u_w.cnt), 2);
        mst_resp.b_valid = 1'b1;
        repeat (2) step();
        mst_resp.b_valid = 1'b0;
        @(negedge clk);
        check("drain_wr_busy", wr_busy, 0);

        // read at limit with a return while a new AR waits
        mst_resp.ar_ready = 1'b1;
        slv_req.ar_valid = 1'b1;
        slv_req.r_ready = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rd_full_ar_ready", slv_resp.ar_ready, 0);
        check("rd_full_mst_ar_valid", mst_req.ar_valid, 0);
        check("rd_full_busy", rd_busy, 1);
        mst_resp.r_valid = 1'b1;
        step();
        mst_resp.r_valid = 1'b0;
        @(negedge clk);
        check("rd_reopen_ar_ready", slv_resp.ar_ready, 1);
        step();
        check("rd_limit_ar_cnt", 32'(dut.u_ar.cnt), 2);

        // simultaneous AR and R below the limit
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        step();
        check("rd_below_ar_cnt", 32'(dut.u_ar.cnt), 1);
        slv_req.ar_valid = 1'b1;
        step();
        check("simul_ar_cnt", 32'(dut.u_ar.cnt), 1);
        slv_req.ar_valid = 1'b0;
        step();
        mst_resp.r_valid = 1'b0;
        @(negedge clk);
        check("rd_drain_busy", rd_busy, 0);
        step();

        // W ahead of AW, one B retires both
        slv_req.w_valid = 1'b1;
        step();
        slv_req.w_valid = 1'b0;
        check("wfirst_w_cnt", 32'(dut.u_w.cnt), 1);
        check("wfirst_aw_cnt", 32'(dut.u_aw.cnt), 0);
        check("wfirst_wr_busy", wr_busy, 1);
        step();
        step();
        slv_req.aw_valid = 1'b1;
        step();
        slv_req.aw_valid = 1'b0;
        check("wfirst_aw_late", 32'(dut.u_aw.cnt), 1);
        step();
        step();
        mst_resp.b_valid = 1'b1;
        step();
        mst_resp.b_valid = 1'b0;
        check("wfirst_aw_done", 32'(dut.u_aw.cnt), 0);
        check("wfirst_w_done", 32'(dut.u_w.cnt), 0);
        check("wfirst_busy_done", wr_busy, 0);

        // stray B with nothing outstanding
        mst_resp.b_valid = 1'b1;
        @(negedge clk);
        check("uf_flag", dut.u_aw.underflow, 1);
        step();
        mst_resp.b_valid = 1'b0;
        check("uf_aw_cnt", 32'(dut.u_aw.cnt), 0);
        check("uf_w_cnt", 32'(dut.u_w.cnt), 0);

        // random traffic against a random-latency slave
        slv_req = '0;
        mst_resp = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        {m_aw, m_w, m_ar, wr_gen, rd_gen, b_dly, r_dly, cyc} = '0;
        {aw_hs, w_hs, ar_hs, b_hs, r_hs, aw_pend, w_pend, ar_pend, done} = '0;
        while (!done && cyc < 90000) begin
            cyc++;
            if (aw_hs) slv_req.aw_valid = 1'b0;
            if (w_hs) slv_req.w_valid = 1'b0;
            if (ar_hs) slv_req.ar_valid = 1'b0;
            if (b_hs) begin
                mst_resp.b_valid = 1'b0;
                b_dly = $urandom_range(4);
            end
            if (r_hs) begin
                mst_resp.r_valid = 1'b0;
                r_dly = $urandom_range(4);
            end
            if (wr_gen < NumWr && aw_q.size() < 3 && $urandom_range(1) == 1) begin
                a = $urandom;
                d = $urandom;
                aw_q.push_back(a);
                w_q.push_back(d);
                exp_b.push_back({^a, ^d});
                wr_gen++;
            end
            if (rd_gen < NumRd && ar_q.size() < 3 && $urandom_range(1) == 1) begin
                a = $urandom;
                ar_q.push_back(a);
                exp_r.push_back(a ^ 32'hA5A5_5A5A);
                rd_gen++;
            end
            if (!slv_req.aw_valid && aw_q.size() > 0 && $urandom_range(3) != 0) begin
                slv_req.aw_valid = 1'b1;
                slv_req.aw.addr = aw_q[0];
            end
            if (!slv_req.w_valid && w_q.size() > 0 && $urandom_range(3) != 0) begin
                slv_req.w_valid = 1'b1;
                slv_req.w.data = w_q[0];
                slv_req.w.strb = '1;
            end
            if (!slv_req.ar_valid && ar_q.size() > 0 && $urandom_range(3) != 0) begin
                slv_req.ar_valid = 1'b1;
                slv_req.ar.addr = ar_q[0];
            end
            slv_req.b_ready = $urandom_range(3) != 0;
            slv_req.r_ready = $urandom_range(3) != 0;
            mst_resp.aw_ready = $urandom_range(3) != 0;
            mst_resp.w_ready = $urandom_range(3) != 0;
            mst_resp.ar_ready = $urandom_range(3) != 0;
            if (!mst_resp.b_valid) begin
                if (b_dly > 0) b_dly--;
                else if (s_aw.size() > 0 && s_w.size() > 0) begin
                    a = s_aw.pop_front();
                    d = s_w.pop_front();
                    mst_resp.b_valid = 1'b1;
                    mst_resp.b.resp = {^a, ^d};
                end
            end
            if (!mst_resp.r_valid) begin
                if (r_dly > 0) r_dly--;
                else if (s_ar.size() > 0) begin
                    a = s_ar.pop_front();
                    mst_resp.r_valid = 1'b1;
                    mst_resp.r.data = a ^ 32'hA5A5_5A5A;
                    mst_resp.r.resp = 2'b00;
                end
            end
            @(negedge clk);
            check("aw_gate", slv_resp.aw_ready, 32'(mst_resp.aw_ready && m_aw < MaxWr));
            check("w_gate", slv_resp.w_ready, 32'(mst_resp.w_ready && m_w < MaxWr));
            check("ar_gate", slv_resp.ar_ready, 32'(mst_resp.ar_ready && m_ar < MaxRd));
            check("wr_busy", wr_busy, 32'(m_aw != 0 || m_w != 0));
            check("rd_busy", rd_busy, 32'(m_ar != 0));
            if (aw_pend) check("aw_stable", mst_req.aw_valid, 1);
            if (w_pend) check("w_stable", mst_req.w_valid, 1);
            if (ar_pend) check("ar_stable", mst_req.ar_valid, 1);
            aw_hs = mst_req.aw_valid && mst_resp.aw_ready;
            w_hs = mst_req.w_valid && mst_resp.w_ready;
            ar_hs = mst_req.ar_valid && mst_resp.ar_ready;
            b_hs = slv_resp.b_valid && slv_req.b_ready;
            r_hs = slv_resp.r_valid && slv_req.r_ready;
            aw_pend = mst_req.aw_valid && !mst_resp.aw_ready;
            w_pend = mst_req.w_valid && !mst_resp.w_ready;
            ar_pend = mst_req.ar_valid && !mst_resp.ar_ready;
            if (aw_hs) begin
                s_aw.push_back(mst_req.aw.addr);
                void'(aw_q.pop_front());
                m_aw++;
            end
            if (w_hs) begin
                s_w.push_back(mst_req.w.data);
                void'(w_q.pop_front());
                m_w++;
            end
            if (ar_hs) begin
                s_ar.push_back(mst_req.ar.addr);
                void'(ar_q.pop_front());
                m_ar++;
            end
            if (b_hs) begin
                if (exp_b.size() == 0) check("b_unexpected", 32'(exp_b.size()), 1);
                else check("b_resp", slv_resp.b.resp, exp_b.pop_front());
                if (m_aw > 0) m_aw--;
                if (m_w > 0) m_w--;
            end
            if (r_hs) begin
                if (exp_r.size() == 0) check("r_unexpected", 32'(exp_r.size()), 1);
                else check("r_data", slv_resp.r.data, exp_r.pop_front());
                if (m_ar > 0) m_ar--;
            end
            done = wr_gen == NumWr && rd_gen == NumRd && exp_b.size() == 0 && exp_r.size() == 0;
            step();
        end
        check("rand_complete", done, 1);
        check("rand_b_drained", 32'(exp_b.size()), 0);
        check("rand_r_drained", 32'(exp_r.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
